// File: rtl/qtable_best_hop.sv
// Read-only scan of the neighbor Q-table: picks the highest-Q neighbor whose remaining
// energy meets ENERGY_MIN and returns its ID, Q-value, energy and cluster ID.
module qtable_best_hop #(
  parameter int unsigned MAX_NEIGHBORS = 32,
  parameter logic [15:0] ENERGY_MIN    = 16'd0
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic [15:0] best_id,
  output logic [15:0] best_qvalue,
  output logic [15:0] best_energy,
  output logic [15:0] best_cluster,
  output logic        valid,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IdxW = $clog2(MAX_NEIGHBORS);
  localparam int unsigned CntW = IdxW + 1;

  localparam logic [10:0] CntAddr = 11'h274;
  localparam logic [10:0] IdBase  = 11'h072;
  localparam logic [10:0] ClBase  = 11'h0B2;
  localparam logic [10:0] EnBase  = 11'h0F2;
  localparam logic [10:0] QBase   = 11'h132;

  typedef enum logic [2:0] {StIdle, StCnt, StQ, StE, StSel, StId, StCl, StDone} state_e;

  state_e            state_q, state_d;
  logic [10:0]       addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   n_q, n_d;
  logic [IdxW-1:0]   best_n_q, best_n_d;
  logic [15:0]       q_cur_q, q_cur_d;
  logic              found_q, found_d;
  logic [15:0]       best_id_q, best_id_d;
  logic [15:0]       best_qvalue_q, best_qvalue_d;
  logic [15:0]       best_energy_q, best_energy_d;
  logic [15:0]       best_cluster_q, best_cluster_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [CntW-1:0]   cnt_clamp;
  logic [CntW-1:0]   n_inc;
  logic [16:0]       energy_diff;
  logic              eligible;

  // Each entry occupies two words, so the index becomes a doubled word offset.
  function automatic logic [10:0] entry_ofs(input logic [IdxW-1:0] idx);
    return 11'({idx, 1'b0});
  endfunction

  assign cnt_clamp   = (data_in > 16'(MAX_NEIGHBORS)) ? CntW'(MAX_NEIGHBORS)
                                                       : data_in[CntW-1:0];
  assign n_inc       = {1'b0, n_q} + CntW'(1);
  // No borrow out of the subtraction means data_in >= ENERGY_MIN (unsigned).
  assign energy_diff = {1'b0, data_in} - {1'b0, ENERGY_MIN};
  assign eligible    = ~energy_diff[16];

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    n_d            = n_q;
    best_n_d       = best_n_q;
    q_cur_d        = q_cur_q;
    found_d        = found_q;
    best_id_d      = best_id_q;
    best_qvalue_d  = best_qvalue_q;
    best_energy_d  = best_energy_q;
    best_cluster_d = best_cluster_q;
    valid_d        = valid_q;
    done_d         = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) begin
          state_d        = StCnt;
          addr_d         = CntAddr;
          n_d            = '0;
          best_n_d       = '0;
          found_d        = 1'b0;
          valid_d        = 1'b0;
          best_id_d      = '0;
          best_qvalue_d  = '0;
          best_energy_d  = '0;
          best_cluster_d = '0;
        end
      end
      StCnt: begin
        cnt_d = cnt_clamp;
        if (cnt_clamp == '0) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          state_d = StDone;
        end else begin
          addr_d  = QBase;
          state_d = StQ;
        end
      end
      StQ: begin
        q_cur_d = data_in;
        addr_d  = EnBase + entry_ofs(n_q);
        state_d = StE;
      end
      StE: begin
        // Strict compare: on equal Q the earlier index stays selected.
        if (eligible && (!found_q || (q_cur_q > best_qvalue_q))) begin
          best_qvalue_d = q_cur_q;
          best_energy_d = data_in;
          best_n_d      = n_q;
          found_d       = 1'b1;
        end
        if (n_inc == cnt_q) begin
          state_d = StSel;
        end else begin
          n_d     = n_inc[IdxW-1:0];
          addr_d  = QBase + entry_ofs(n_inc[IdxW-1:0]);
          state_d = StQ;
        end
      end
      StSel: begin
        if (found_q) begin
          addr_d  = IdBase + entry_ofs(best_n_q);
          state_d = StId;
        end else begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          state_d = StDone;
        end
      end
      StId: begin
        best_id_d = data_in;
        addr_d    = ClBase + entry_ofs(best_n_q);
        state_d   = StCl;
      end
      StCl: begin
        best_cluster_d = data_in;
        valid_d        = 1'b1;
        done_d         = 1'b1;
        state_d        = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      cnt_q          <= '0;
      n_q            <= '0;
      best_n_q       <= '0;
      q_cur_q        <= '0;
      found_q        <= 1'b0;
      best_id_q      <= '0;
      best_qvalue_q  <= '0;
      best_energy_q  <= '0;
      best_cluster_q <= '0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      n_q            <= n_d;
      best_n_q       <= best_n_d;
      q_cur_q        <= q_cur_d;
      found_q        <= found_d;
      best_id_q      <= best_id_d;
      best_qvalue_q  <= best_qvalue_d;
      best_energy_q  <= best_energy_d;
      best_cluster_q <= best_cluster_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
    end
  end

  assign address      = addr_q;
  assign best_id      = best_id_q;
  assign best_qvalue  = best_qvalue_q;
  assign best_energy  = best_energy_q;
  assign best_cluster = best_cluster_q;
  assign valid        = valid_q;
  assign done         = done_q;
  assign busy         = (state_q != StIdle) && (state_q != StDone);

endmodule
